// File: rtl/ula_sequencer_if.sv
// Purpose: handshake and strobe bundle between the host, ula_sequencer and the ULA register bank.
// Latency: none; this is a wiring bundle only.
// Backpressure: start is only honoured while ready=1. The sequencer cannot be stalled once it has accepted start.
// Ports: start/opcode/abort come from the host. The other signals are decoded state from the sequencer.
interface ula_sequencer_if #(
    parameter int OP_W = 3
);
    logic            start;
    logic [OP_W-1:0] opcode;
    logic            abort;
    logic            ready;
    logic            busy;
    logic            load_a;
    logic            load_b;
    logic [OP_W-1:0] alu_op;
    logic            alu_en;
    logic            load_res;
    logic            load_flags;
    logic            done;
    logic            err;

    // Host / control side
    modport master (
        output start, opcode, abort,
        input  ready, busy, load_a, load_b, alu_op, alu_en,
               load_res, load_flags, done, err
    );

    // Sequencer side
    modport slave (
        input  start, opcode, abort,
        output ready, busy, load_a, load_b, alu_op, alu_en,
               load_res, load_flags, done, err
    );
endinterface

// File: rtl/ula_sequencer.sv
// Purpose: Moore FSM that sequences one ULA operation: operand load, execute, result/flags write, then a done pulse.
// Latency: start accepted at edge k gives done in cycle k+4. Opcode 3'b110 gives done in cycle k+3+MULTI_CYC. Reserved opcode 3'b111 gives err in cycle k+1.
// Backpressure: ready=1 only in IDLE, so one request is in flight at a time. abort cancels the request during LOAD/EXEC only.
// Ports: clock, reset_n (synchronous, active low), bus (slave modport of ula_sequencer_if).
module ula_sequencer #(
    parameter int OP_W      = 3,
    parameter int MULTI_CYC = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    ula_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_MULTI = OP_W'(3'b110);
    localparam logic [OP_W-1:0] OP_RSVD  = OP_W'(3'b111);
    // The counter holds the number of extra EXEC cycles still to run.
    localparam logic [3:0]      CNT_INIT = 4'(MULTI_CYC - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                // abort has no effect here. The opcode register is only updated for legal requests.
                if (bus.start) begin
                    if (bus.opcode == OP_RSVD) begin
                        state_d = ERR;
                    end else begin
                        op_d    = bus.opcode;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = (op_q == OP_MULTI) ? CNT_INIT : 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is decoded from registered state only, so no input reaches an output combinationally.
    always_comb begin
        bus.ready      = (state_q == IDLE);
        bus.busy       = (state_q != IDLE);
        bus.load_a     = (state_q == LOAD);
        bus.load_b     = (state_q == LOAD);
        bus.alu_en     = (state_q == EXEC);
        bus.load_res   = (state_q == WRITE);
        bus.load_flags = (state_q == WRITE);
        bus.done       = (state_q == DONE);
        bus.err        = (state_q == ERR);
        bus.alu_op     = op_q;
    end

endmodule

// File: tb/tb_ula_sequencer.sv
// Purpose: self-checking bench for ula_sequencer. A schedule-queue reference model is compared against every output on every cycle.
// Latency: each stimulus cycle drives inputs, waits one rising edge, then samples outputs 1 time unit later.
// Backpressure: start is driven freely. The model decides acceptance from its own idle/busy view.
module tb_ula_sequencer;

    localparam int MULTI = 4;

    // Phases of one operation, as the model tracks them
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_EXEC  = 2;
    localparam int P_WRITE = 3;
    localparam int P_DONE  = 4;
    localparam int P_ERR   = 5;

    logic clock = 1'b0;
    logic reset_n;

    ula_sequencer_if #(.OP_W(3)) bus ();

    ula_sequencer #(.OP_W(3), .MULTI_CYC(MULTI)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state: the current phase plus the remaining phases of the operation
    int         m_ph = P_IDLE;
    int         m_q[$];
    logic [2:0] m_op = 3'd0;

    int cyc      = 0;
    int acc_cyc  = -1;
    int done_cyc = -1;
    int n_load, n_en, n_res, n_done, n_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_ph = P_IDLE;
            m_q.delete();
            m_op = 3'd0;
        end else if (m_ph == P_IDLE) begin
            if (bus.start) begin
                if (bus.opcode == 3'b111) begin
                    m_ph = P_ERR;
                end else begin
                    m_op    = bus.opcode;
                    m_ph    = P_LOAD;
                    acc_cyc = cyc;
                    m_q.delete();
                    for (int i = 0; i < ((bus.opcode == 3'b110) ? MULTI : 1); i++)
                        m_q.push_back(P_EXEC);
                    m_q.push_back(P_WRITE);
                    m_q.push_back(P_DONE);
                end
            end
        end else if (bus.abort && (m_ph == P_LOAD || m_ph == P_EXEC)) begin
            m_ph = P_IDLE;
            m_q.delete();
        end else if (m_q.size() > 0) begin
            m_ph = m_q.pop_front();
        end else begin
            m_ph = P_IDLE;
        end
    endtask

    task automatic check_outputs();
        check_val("ready",      32'(bus.ready),      32'(m_ph == P_IDLE));
        check_val("busy",       32'(bus.busy),       32'(m_ph != P_IDLE));
        check_val("load_a",     32'(bus.load_a),     32'(m_ph == P_LOAD));
        check_val("load_b",     32'(bus.load_b),     32'(m_ph == P_LOAD));
        check_val("alu_en",     32'(bus.alu_en),     32'(m_ph == P_EXEC));
        check_val("load_res",   32'(bus.load_res),   32'(m_ph == P_WRITE));
        check_val("load_flags", 32'(bus.load_flags), 32'(m_ph == P_WRITE));
        check_val("done",       32'(bus.done),       32'(m_ph == P_DONE));
        check_val("err",        32'(bus.err),        32'(m_ph == P_ERR));
        check_val("alu_op",     32'(bus.alu_op),     32'(m_op));
    endtask

    task automatic run_cycle(input logic rn, input logic st, input logic [2:0] op, input logic ab);
        reset_n    = rn;
        bus.start  = st;
        bus.opcode = op;
        bus.abort  = ab;
        @(posedge clock);
        cyc++;
        model_step();
        #1;
        check_outputs();
        if (bus.load_a)   n_load++;
        if (bus.alu_en)   n_en++;
        if (bus.load_res) n_res++;
        if (bus.err)      n_err++;
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_counts();
        n_load = 0; n_en = 0; n_res = 0; n_done = 0; n_err = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    int first_done;

    initial begin
        clear_counts();

        // Reset held with start asserted: nothing may be accepted.
        run_cycle(1'b0, 1'b1, 3'b010, 1'b0);
        run_cycle(1'b0, 1'b1, 3'b010, 1'b0);
        check_val("reset_no_accept", 32'(n_load + n_en + n_done + n_err), 32'd0);
        // First edge after release with start=1 accepts.
        run_cycle(1'b1, 1'b1, 3'b010, 1'b0);
        check_val("first_accept_load", 32'(bus.load_a), 32'd1);
        idle_cycles(6);

        // Single-cycle op: done in cycle k+4.
        clear_counts();
        run_cycle(1'b1, 1'b1, 3'b001, 1'b0);
        idle_cycles(5);
        check_val("single_lat",  32'(done_cyc - acc_cyc + 1), 32'd4);
        check_val("single_en",   32'(n_en),   32'd1);
        check_val("single_load", 32'(n_load), 32'd1);
        check_val("single_res",  32'(n_res),  32'd1);
        check_val("single_done", 32'(n_done), 32'd1);

        // Multi-cycle op: MULTI consecutive EXEC cycles, done in cycle k+3+MULTI.
        clear_counts();
        run_cycle(1'b1, 1'b1, 3'b110, 1'b0);
        idle_cycles(MULTI + 4);
        check_val("multi_en",  32'(n_en), 32'(MULTI));
        check_val("multi_lat", 32'(done_cyc - acc_cyc + 1), 32'(3 + MULTI));

        // Reserved opcode: err only, no strobes.
        clear_counts();
        run_cycle(1'b1, 1'b1, 3'b111, 1'b0);
        run_cycle(1'b1, 1'b0, 3'b000, 1'b0);
        check_val("rsvd_ready", 32'(bus.ready), 32'd1);
        check_val("rsvd_err",   32'(n_err),     32'd1);
        check_val("rsvd_strb",  32'(n_load + n_en + n_res + n_done), 32'd0);

        // Abort during the second EXEC cycle of opcode 6.
        clear_counts();
        run_cycle(1'b1, 1'b1, 3'b110, 1'b0);   // LOAD
        run_cycle(1'b1, 1'b0, 3'b000, 1'b0);   // EXEC 1
        run_cycle(1'b1, 1'b0, 3'b000, 1'b0);   // EXEC 2
        run_cycle(1'b1, 1'b0, 3'b000, 1'b1);   // abort sampled in EXEC 2
        check_val("abort_idle", 32'(bus.ready), 32'd1);
        idle_cycles(MULTI + 3);
        check_val("abort_nores",  32'(n_res),  32'd0);
        check_val("abort_nodone", 32'(n_done), 32'd0);

        // Abort sampled in WRITE is ignored.
        clear_counts();
        run_cycle(1'b1, 1'b1, 3'b011, 1'b0);   // LOAD
        run_cycle(1'b1, 1'b0, 3'b000, 1'b0);   // EXEC
        run_cycle(1'b1, 1'b0, 3'b000, 1'b0);   // WRITE
        run_cycle(1'b1, 1'b0, 3'b000, 1'b1);   // abort in WRITE
        idle_cycles(2);
        check_val("abort_write_done", 32'(n_done), 32'd1);

        // Back-to-back with start held: second accept two edges after done is seen.
        clear_counts();
        run_cycle(1'b1, 1'b1, 3'b100, 1'b0);
        first_done = -1;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b1, 3'b100, 1'b0);
            if (bus.done && first_done < 0) first_done = cyc;
        end
        check_val("b2b_gap", 32'(acc_cyc - first_done), 32'd2);
        idle_cycles(6);

        // Reset during EXEC.
        clear_counts();
        run_cycle(1'b1, 1'b1, 3'b110, 1'b0);
        run_cycle(1'b1, 1'b0, 3'b000, 1'b0);
        run_cycle(1'b0, 1'b0, 3'b000, 1'b0);
        check_val("midrst_ready", 32'(bus.ready), 32'd1);
        check_val("midrst_op",    32'(bus.alu_op), 32'd0);
        idle_cycles(MULTI + 3);
        check_val("midrst_nodone", 32'(n_done + n_res), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            run_cycle(($urandom_range(0, 63) != 0),
                      ($urandom_range(0, 1) == 1),
                      3'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
